// File: rtl/wb_write_queue_pkg.sv
// wb_write_queue_pkg: shared processor widths, zero-register constant and the
// write-back entry type. Revision 1.0
`default_nettype none

package wb_write_queue_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [WB_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_bypass_match.sv
// wb_bypass_match: finds the youngest valid queued entry whose destination
// matches idx. Revision 1.0
`default_nettype none

module wb_bypass_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [WB_ADDR_W-1:0]         idx,
  output logic                         hit,
  output logic [WB_DATA_W-1:0]         data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (idx != ZERO_REG && valid[slot] && entries[slot].rd == idx) begin
        hit  = 1'b1;
        data = entries[slot].data;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_write_queue.sv
// wb_write_queue: circular write-back queue merging ALU and load results into
// one register-file write port, with decode-stage bypass. Revision 1.0
`default_nettype none

module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aluValid,
  input  logic [ADDR_W-1:0]          aluReg,
  input  logic [DATA_W-1:0]          aluData,
  output logic                       aluReady,
  input  logic                       memValid,
  input  logic [ADDR_W-1:0]          memReg,
  input  logic [DATA_W-1:0]          memData,
  output logic                       memReady,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          writeReg,
  output logic [DATA_W-1:0]          writeData,
  input  logic [ADDR_W-1:0]          readRegA,
  input  logic [ADDR_W-1:0]          readRegB,
  output logic                       hitA,
  output logic                       hitB,
  output logic [DATA_W-1:0]          bypassA,
  output logic [DATA_W-1:0]          bypassB,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ONE_FREE = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] TWO_FREE = CNT_W'(DEPTH - 2);

  // Entry storage follows the package widths; ports are cast onto it.
  wb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   mem_slot;
  logic [CNT_W-1:0]   count_r;
  logic [DEPTH-1:0]   valid;
  logic               alu_acc, mem_acc, alu_enq, mem_enq, pop;
  logic               hit_a, hit_b;
  logic [WB_DATA_W-1:0] data_a, data_b;

  assign aluReady = (count_r <= ONE_FREE);
  assign memReady = aluValid ? (count_r <= TWO_FREE) : (count_r <= ONE_FREE);

  // Nothing is accepted while reset is held, whatever the ready lines show.
  assign alu_acc  = rst_n && aluValid && aluReady;
  assign mem_acc  = rst_n && memValid && memReady;
  assign alu_enq  = alu_acc && (WB_ADDR_W'(aluReg) != ZERO_REG);
  assign mem_enq  = mem_acc && (WB_ADDR_W'(memReg) != ZERO_REG);
  assign pop      = (count_r != '0);
  assign mem_slot = tail + PTR_W'(alu_enq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      head    <= head + PTR_W'(pop);
      tail    <= tail + PTR_W'(alu_enq) + PTR_W'(mem_enq);
      count_r <= count_r + CNT_W'(alu_enq) + CNT_W'(mem_enq) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (alu_enq) entries[tail]     <= '{rd: WB_ADDR_W'(aluReg), data: WB_DATA_W'(aluData)};
    if (mem_enq) entries[mem_slot] <= '{rd: WB_ADDR_W'(memReg), data: WB_DATA_W'(memData)};
  end

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - head} < count_r);
    end
  end

  assign count     = count_r;
  assign RegWrite  = pop;
  assign writeReg  = ADDR_W'(entries[head].rd);
  assign writeData = DATA_W'(entries[head].data);

  wb_bypass_match #(.DEPTH(DEPTH)) u_bypass_a (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .idx     (WB_ADDR_W'(readRegA)),
    .hit     (hit_a),
    .data    (data_a)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_bypass_b (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .idx     (WB_ADDR_W'(readRegB)),
    .hit     (hit_b),
    .data    (data_b)
  );

  assign hitA    = hit_a;
  assign hitB    = hit_b;
  assign bypassA = DATA_W'(data_a);
  assign bypassB = DATA_W'(data_b);

endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed vector table plus randomized traffic against a
// queue-based reference model. Revision 1.0
`default_nettype none

module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        aluValid, memValid;
  logic [4:0]  aluReg, memReg, readRegA, readRegB;
  logic [31:0] aluData, memData;
  logic        aluReady, memReady, RegWrite, hitA, hitB;
  logic [4:0]  writeReg;
  logic [31:0] writeData, bypassA, bypassB;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .readRegA(readRegA), .readRegB(readRegB),
    .hitA(hitA), .hitB(hitB), .bypassA(bypassA), .bypassB(bypassB),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        av;  logic [4:0] ar; logic [31:0] ad;
    logic        mv;  logic [4:0] mr; logic [31:0] md;
    logic [4:0]  ra;  logic [4:0] rb;
    logic [2:0]  cnt; logic we; logic [4:0] wr; logic [31:0] wd;
    logic        ha;  logic [31:0] ba;
    logic        hb;  logic [31:0] bb;
    logic        ardy; logic mrdy;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t tbl [23];
  ent_t q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag, logic [2:0] e_cnt, logic e_we, logic [4:0] e_wr,
                           logic [31:0] e_wd, logic e_ha, logic [31:0] e_ba,
                           logic e_hb, logic [31:0] e_bb, logic e_ardy, logic e_mrdy);
    chk({tag, ".count"},    32'(count),    32'(e_cnt));
    chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(e_we));
    if (e_we) begin
      chk({tag, ".writeReg"},  32'(writeReg), 32'(e_wr));
      chk({tag, ".writeData"}, writeData,     e_wd);
    end
    chk({tag, ".hitA"},     32'(hitA),     32'(e_ha));
    chk({tag, ".bypassA"},  bypassA,       e_ba);
    chk({tag, ".hitB"},     32'(hitB),     32'(e_hb));
    chk({tag, ".bypassB"},  bypassB,       e_bb);
    chk({tag, ".aluReady"}, 32'(aluReady), 32'(e_ardy));
    chk({tag, ".memReady"}, 32'(memReady), 32'(e_mrdy));
  endtask

  task automatic drive(logic r, logic av, logic [4:0] ar, logic [31:0] ad,
                       logic mv, logic [4:0] mr, logic [31:0] md,
                       logic [4:0] ra, logic [4:0] rb);
    rst_n = r; aluValid = av; aluReg = ar; aluData = ad;
    memValid = mv; memReg = mr; memData = md; readRegA = ra; readRegB = rb;
  endtask

  function automatic void lookup(logic [4:0] idx, output logic h, output logic [31:0] d);
    h = 1'b0; d = 32'h0;
    if (idx != 5'd0) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].rd == idx) begin h = 1'b1; d = q[k].data; break; end
      end
    end
  endfunction

  initial begin
    //        rst  av ar     ad            mv mr     md          ra     rb     cnt  we wr     wd            ha  ba            hb  bb          ardy mrdy
    tbl[0]  = '{1'b0, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[1]  = '{1'b1, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,    5'd5,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[2]  = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd5,  5'd0,  3'd1,1'b1,5'd5,32'hDEADBEEF, 1'b1,32'hDEADBEEF, 1'b0,32'h0,    1'b1,1'b1};
    tbl[3]  = '{1'b1, 1'b1,5'd3,32'h11,       1'b1,5'd7,32'h22,   5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[4]  = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd3,  5'd7,  3'd2,1'b1,5'd3,32'h11,       1'b1,32'h11,       1'b1,32'h22,   1'b1,1'b1};
    tbl[5]  = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd0,  5'd7,  3'd1,1'b1,5'd7,32'h22,       1'b0,32'h0,        1'b1,32'h22,   1'b1,1'b1};
    tbl[6]  = '{1'b1, 1'b1,5'd1,32'hA1,       1'b1,5'd2,32'hA2,   5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[7]  = '{1'b1, 1'b1,5'd3,32'hA3,       1'b1,5'd4,32'hA4,   5'd0,  5'd0,  3'd2,1'b1,5'd1,32'hA1,       1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[8]  = '{1'b1, 1'b1,5'd5,32'hA5,       1'b1,5'd6,32'hA6,   5'd0,  5'd0,  3'd3,1'b1,5'd2,32'hA2,       1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b0};
    tbl[9]  = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd5,  5'd6,  3'd3,1'b1,5'd3,32'hA3,       1'b1,32'hA5,       1'b0,32'h0,    1'b1,1'b1};
    tbl[10] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd0,  5'd0,  3'd2,1'b1,5'd4,32'hA4,       1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[11] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd0,  5'd0,  3'd1,1'b1,5'd5,32'hA5,       1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[12] = '{1'b1, 1'b1,5'd9,32'h1,        1'b1,5'd9,32'h2,    5'd9,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[13] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd9,  5'd0,  3'd2,1'b1,5'd9,32'h1,        1'b1,32'h2,        1'b0,32'h0,    1'b1,1'b1};
    tbl[14] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd9,  5'd0,  3'd1,1'b1,5'd9,32'h2,        1'b1,32'h2,        1'b0,32'h0,    1'b1,1'b1};
    tbl[15] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd9,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[16] = '{1'b1, 1'b1,5'd0,32'hFFFF,     1'b0,5'd0,32'h0,    5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[17] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[18] = '{1'b1, 1'b1,5'd1,32'h51,       1'b1,5'd2,32'h52,   5'd0,  5'd0,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[19] = '{1'b1, 1'b1,5'd3,32'h53,       1'b1,5'd4,32'h54,   5'd0,  5'd0,  3'd2,1'b1,5'd1,32'h51,       1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[20] = '{1'b0, 1'b1,5'd6,32'h66,       1'b0,5'd0,32'h0,    5'd2,  5'd0,  3'd3,1'b1,5'd2,32'h52,       1'b1,32'h52,       1'b0,32'h0,    1'b1,1'b0};
    tbl[21] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd6,  5'd2,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};
    tbl[22] = '{1'b1, 1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,    5'd3,  5'd4,  3'd0,1'b0,5'd0,32'h0,        1'b0,32'h0,        1'b0,32'h0,    1'b1,1'b1};

    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst_n, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr,
            tbl[i].md, tbl[i].ra, tbl[i].rb);
      #3;
      check_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].we, tbl[i].wr, tbl[i].wd,
                tbl[i].ha, tbl[i].ba, tbl[i].hb, tbl[i].bb, tbl[i].ardy, tbl[i].mrdy);
      @(posedge clk);
      #1;
    end

    // Randomized traffic: the queue is empty after the table.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic        r, av, mv, e_ha, e_hb, e_ardy, e_mrdy, e_we;
      logic [4:0]  ar, mr, ra, rb, e_wr;
      logic [31:0] ad, md, e_ba, e_bb, e_wd;
      int          n;
      r  = ($urandom_range(0, 59) != 0);
      av = ($urandom_range(0, 2) != 0);
      mv = ($urandom_range(0, 2) != 0);
      ar = 5'($urandom_range(0, 7));
      mr = 5'($urandom_range(0, 7));
      ad = $urandom;
      md = $urandom;
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      drive(r, av, ar, ad, mv, mr, md, ra, rb);

      n      = q.size();
      e_ardy = (n <= DEPTH - 1);
      e_mrdy = av ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
      e_we   = (n != 0);
      e_wr   = e_we ? q[0].rd : 5'd0;
      e_wd   = e_we ? q[0].data : 32'h0;
      lookup(ra, e_ha, e_ba);
      lookup(rb, e_hb, e_bb);
      #3;
      check_all($sformatf("rnd%0d", c), 3'(n), e_we, e_wr, e_wd,
                e_ha, e_ba, e_hb, e_bb, e_ardy, e_mrdy);
      @(posedge clk);
      #1;

      if (!r) begin
        q.delete();
      end else begin
        if (n != 0) void'(q.pop_front());
        if (av && e_ardy && ar != 5'd0) q.push_back('{rd: ar, data: ad});
        if (mv && e_mrdy && mr != 5'd0) q.push_back('{rd: mr, data: md});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
